// File: rtl/cpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_pkg
// Shared types and default widths for the CPU memory port logic.
//   arb_state_e : arbiter FSM states (IDLE / ISSUE / DONE)
//   owner_e     : current bus owner encoding, also exported as a debug port
//   ADDR_W_DEF / DATA_W_DEF : default address and data widths
// ---------------------------------------------------------------------------
package cpu_mem_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DONE  = 2'b10
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_IF   = 2'b01,
    OWN_D    = 2'b10
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch and the data
// path. One transaction at a time runs over a mem_req/mem_ack handshake;
// completion and read data go back to the requester that won arbitration.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   if_req/if_addr                 fetch request (level) and address
//   if_rdata/if_ack                fetched word and one-cycle completion
//   d_req/d_we/d_addr/d_wdata      data request, direction, address, write data
//   d_rdata/d_ack                  read word and one-cycle completion
//   mem_req/mem_we/mem_addr/mem_wdata  memory request side (level req)
//   mem_rdata/mem_ack              memory response (single-cycle ack)
//   bus_err                        pulses with the ack of a timed-out access
//   owner                          debug: 00 none, 01 fetch, 10 data
//
// Data normally wins arbitration, but after MAX_D_STREAK consecutive data
// grants with fetch waiting, fetch is forced through. An access that sees no
// mem_ack within TIMEOUT_CYC cycles is aborted and completed with bus_err.
// All outputs are registered.
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT_CYC  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err,
  output logic [1:0]        owner
);

  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);

  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYC - 1);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [SW-1:0]     streak_q, streak_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;

  logic              mem_req_d, mem_we_d, if_ack_d, d_ack_d, bus_err_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d, if_rdata_d, d_rdata_d;
  logic              fetch_wins;
  logic              timed_out;

  assign owner = owner_q;

  // Fetch takes the bus when data is idle, or when data has already had its
  // full streak of grants while fetch was waiting.
  assign fetch_wins = if_req && (!d_req || (streak_q == STREAK_MAX));

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    tcnt_d      = tcnt_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    bus_err_d   = 1'b0;
    timed_out   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!if_req) streak_d = '0;
        if (d_req && !fetch_wins) begin
          owner_d     = OWN_D;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_req_d   = 1'b1;
          state_d     = ISSUE;
          // Only grants that made fetch wait count toward the streak.
          if (if_req && (streak_q != STREAK_MAX)) streak_d = streak_q + SW'(1);
        end else if (if_req) begin
          owner_d    = OWN_IF;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          mem_req_d  = 1'b1;
          streak_d   = '0;
          state_d    = ISSUE;
        end
      end

      ISSUE: begin
        // A response in the final allowed cycle still counts as success.
        timed_out = !mem_ack && (tcnt_q == TO_LAST);
        if (mem_ack || timed_out) begin
          mem_req_d = 1'b0;
          state_d   = DONE;
          bus_err_d = timed_out;
          if (owner_q == OWN_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = timed_out ? '0 : mem_rdata;
          end else begin
            d_ack_d = 1'b1;
            if (timed_out)    d_rdata_d = '0;
            else if (!mem_we) d_rdata_d = mem_rdata;
          end
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end

      DONE: begin
        // The ack is visible this cycle; arbitration resumes only next cycle,
        // so a requester still holding req here is not granted twice.
        owner_d = OWN_NONE;
        tcnt_d  = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_NONE;
      streak_q  <= '0;
      tcnt_q    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      streak_q  <= streak_d;
      tcnt_q    <= tcnt_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_rdata  <= if_rdata_d;
      d_rdata   <= d_rdata_d;
      if_ack    <= if_ack_d;
      d_ack     <= d_ack_d;
      bus_err   <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter: fetch read, data read/write,
// contention with the fetch-starvation limit, timeout abort, ack/timeout
// race and asynchronous reset during an access.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        bus_err;
  logic [1:0]  owner;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(
    .ADDR_W(16), .DATA_W(16), .MAX_D_STREAK(4), .TIMEOUT_CYC(64)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err), .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected owner for each grant while both requesters hold req.
  logic [1:0] exp_own [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
  int cnt;

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
    #12;
    check("rst_mem_req", mem_req, 0);
    check("rst_owner",   owner, 0);
    check("rst_acks",    {if_ack, d_ack, bus_err}, 0);
    check("rst_rdata",   {if_rdata, d_rdata}, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---- fetch only: req at N, mem_ack at N+2, if_ack at N+3 ----
    if_req = 1'b1; if_addr = 16'h0040;                 // cycle N
    tick();                                             // N+1
    check("f_mem_req",  mem_req, 1);
    check("f_mem_we",   mem_we, 0);
    check("f_mem_addr", mem_addr, 16'h0040);
    check("f_owner",    owner, 2'b01);
    tick();                                             // N+2
    check("f_req_held", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 16'hA5A5;
    tick();                                             // N+3
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    check("f_if_ack",   if_ack, 1);
    check("f_if_rdata", if_rdata, 16'hA5A5);
    check("f_d_ack",    d_ack, 0);
    check("f_req_drop", mem_req, 0);
    tick();                                             // N+4, req still held
    check("f_ack_pulse", if_ack, 0);
    check("f_owner_clr", owner, 0);
    if_req = 1'b0;
    tick();
    check("f_no_regrant", mem_req, 0);

    // ---- data read, then data write leaves d_rdata untouched ----
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010;
    tick();
    check("dr_owner", owner, 2'b10);
    check("dr_addr",  mem_addr, 16'h0010);
    mem_ack = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    check("dr_d_ack",  d_ack, 1);
    check("dr_rdata",  d_rdata, 16'hBEEF);
    check("dr_if_ack", if_ack, 0);
    d_req = 1'b0;
    tick();

    d_req = 1'b1; d_we = 1'b1; d_addr = 16'hFFFE; d_wdata = 16'h1234;
    tick();
    check("dw_we",    mem_we, 1);
    check("dw_addr",  mem_addr, 16'hFFFE);
    check("dw_wdata", mem_wdata, 16'h1234);
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    tick();
    mem_ack = 1'b0; mem_rdata = 16'h0000;
    check("dw_d_ack", d_ack, 1);
    check("dw_rdata_kept", d_rdata, 16'hBEEF);
    check("dw_bus_err", bus_err, 0);
    d_req = 1'b0; d_we = 1'b0;
    tick();

    // ---- contention: order D,D,D,D,IF,D at 3 cycles per grant ----
    if_req = 1'b1; if_addr = 16'h0100;
    d_req  = 1'b1; d_addr  = 16'h0200;
    for (int g = 0; g < 6; g++) begin
      tick();                                           // ISSUE
      check($sformatf("ct_owner%0d", g), owner, exp_own[g]);
      check($sformatf("ct_addr%0d", g), mem_addr,
            (exp_own[g] == 2'b01) ? 16'h0100 : 16'h0200);
      mem_ack = 1'b1; mem_rdata = 16'h1110 + 16'(g);
      tick();                                           // DONE
      mem_ack = 1'b0;
      check($sformatf("ct_acks%0d", g), {if_ack, d_ack},
            (exp_own[g] == 2'b01) ? 2'b10 : 2'b01);
      tick();                                           // IDLE
    end
    if_req = 1'b0; d_req = 1'b0;
    check("ct_last_rdata", d_rdata, 16'h1115);
    tick();

    // ---- timeout: mem_req held 64 cycles, then d_ack + bus_err, rdata 0 ----
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
    tick();
    cnt = 0;
    while (mem_req && cnt < 200) begin
      cnt++;
      tick();
    end
    check("to_req_cycles", cnt, 64);
    check("to_d_ack",   d_ack, 1);
    check("to_bus_err", bus_err, 1);
    check("to_rdata",   d_rdata, 0);
    d_req = 1'b0;
    tick();
    check("to_err_pulse", bus_err, 0);
    check("to_owner_clr", owner, 0);

    // Next access after a timeout completes normally.
    d_req = 1'b1; d_addr = 16'h0301;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h7777;
    tick();
    mem_ack = 1'b0;
    check("to_next_rdata", d_rdata, 16'h7777);
    check("to_next_err",   bus_err, 0);
    d_req = 1'b0;
    tick();

    // ---- ack on the 64th ISSUE cycle wins over the timeout ----
    d_req = 1'b1; d_addr = 16'h0400;
    tick();                                             // ISSUE cycle 1
    for (int i = 0; i < 63; i++) tick();                // ISSUE cycle 64
    check("race_req_held", mem_req, 1);
    mem_ack = 1'b1; mem_rdata = 16'hCAFE;
    tick();
    mem_ack = 1'b0;
    check("race_d_ack",   d_ack, 1);
    check("race_bus_err", bus_err, 0);
    check("race_rdata",   d_rdata, 16'hCAFE);
    d_req = 1'b0;
    tick();

    // ---- asynchronous reset while a fetch is outstanding ----
    if_req = 1'b1; if_addr = 16'h0500;
    tick();
    check("rr_req_before", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rr_req_async",  mem_req, 0);
    check("rr_owner",      owner, 0);
    check("rr_acks",       {if_ack, d_ack, bus_err}, 0);
    if_req = 1'b0;
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (if_ack || d_ack || mem_req) cnt++;
    end
    check("rr_no_spurious", cnt, 0);

    // Requester re-requests after reset.
    if_req = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 16'h0F0F;
    tick();
    mem_ack = 1'b0;
    check("rr_refetch_ack",   if_ack, 1);
    check("rr_refetch_rdata", if_rdata, 16'h0F0F);
    if_req = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the CPU's single-ported memory between instruction fetch and the data path (LD/ST/PUSH/POP, driven by the decoder's memrd/memwr).
- Arbitrates between the two requesters and runs one memory transaction at a time over a req/ack handshake.
- Returns read data and completion to the winning requester.
- Enforces a fetch-starvation limit and a memory-response timeout.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data word width
MAX_D_STREAK, 4, max consecutive data grants while fetch is pending before fetch is forced
TIMEOUT_CYC, 64, cycles in ISSUE without mem_ack before abort (>=2)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, level, held until if_ack
if_addr  in  ADDR_W  fetch address, stable while if_req
if_rdata  out  DATA_W  fetched word, valid with if_ack
if_ack  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, level, held until d_ack
d_we  in  1  1=write (ST/PUSH), 0=read (LD/POP); stable while d_req
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  write data
d_rdata  out  DATA_W  read word, valid with d_ack
d_ack  out  1  one-cycle data completion pulse
mem_req  out  1  memory request, level, held until mem_ack or timeout
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, single cycle
bus_err  out  1  one-cycle pulse, coincident with the aborting ack on timeout
owner  out  2  00 none, 01 fetch, 10 data (debug)

Behaviour:
- All outputs are registered.
- Reset values: every output 0, FSM IDLE, streak and timeout counters 0.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - Arbitration happens only in this state.
  - No request: stay in IDLE.
  - Priority: data over fetch, except fetch wins when if_req=1 and streak==MAX_D_STREAK.
  - On grant: latch addr, we and wdata into the mem_* registers (a fetch grant sets mem_we=0), set owner, go to ISSUE.
- ISSUE:
  - mem_req=1 for the whole state.
  - mem_ack=1: capture mem_rdata (reads only), drop mem_req, go to DONE.
  - Otherwise the timeout counter increments.
  - Counter reaches TIMEOUT_CYC-1 with no mem_ack: drop mem_req, go to DONE with the error flag set.
  - mem_ack in the same cycle as the timeout: ack wins, no error.
- DONE:
  - Pulse the owner's ack for one cycle.
  - Data reads and fetches update rdata; writes leave d_rdata unchanged.
  - On error, bus_err=1 with the ack and the owner's rdata=0.
  - Then go to IDLE with owner=00 and the timeout counter cleared.
- Latency:
  - Request seen in IDLE at cycle N gives mem_req at N+1.
  - mem_ack at cycle M (M>=N+1) gives the requester ack at M+1; FSM is back in IDLE at M+2.
  - Minimum 3 cycles per transaction.
  - A requester must deassert req (or present a new request) in the cycle after its ack. The DONE state makes a held req safe from double-grant.
- Streak counter:
  - Increments on a data grant when if_req=1.
  - Clears on a fetch grant or on any IDLE cycle with if_req=0.
  - Saturates at MAX_D_STREAK.
- The ack is never asserted on the non-owner requester.
- mem_rdata is ignored outside ISSUE, and for writes.
- Reset mid-transaction: mem_req drops asynchronously, no ack is issued, the requester re-requests after reset.
- Simultaneous if_req and d_req with streak<MAX: data first, fetch next, with no intervening idle beyond the 3-cycle minimum.

Decomposition:
- Shared package cpu_mem_pkg: arb_state_e enum (IDLE/ISSUE/DONE), owner_e encoding (NONE=2'b00, IF=2'b01, D=2'b10), default ADDR_W/DATA_W constants.
- Single module; the timeout counter is small enough to stay inline. No sub-module.

Test Plan:
- Fetch only: if_req, if_addr=16'h0040; mem_ack with mem_rdata=16'hA5A5 one cycle after mem_req -> mem_req at N+1, if_ack and if_rdata=16'hA5A5 at N+3, owner back to 00 at N+4.
- Data write: d_req, d_we=1, d_addr=16'hFFFE, d_wdata=16'h1234 -> mem_we=1, mem_addr=FFFE, mem_wdata=1234; d_ack pulses; d_rdata unchanged from its prior value.
- Contention: if_req and d_req held continuously, data re-requesting after each ack -> grant order D,D,D,D,IF,D,...; fetch granted on the 5th grant.
- Timeout: d_req read, never mem_ack -> mem_req held exactly 64 cycles, then d_ack and bus_err together with d_rdata=0; next grant proceeds normally.
- Ack vs timeout race: mem_ack asserted on the 64th ISSUE cycle -> normal completion, bus_err=0, rdata=mem_rdata.
- Reset mid-ISSUE: assert rst_n=0 asynchronously while mem_req=1 -> mem_req, owner and acks go 0 immediately; after release, IDLE with no spurious ack.
